// File: rtl/shr_seq_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encoding
// and the shift-mode constants selected by the SIGNED parameter.
package shr_seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int SHIFT_LOGICAL = 0;
    localparam int SHIFT_ARITH   = 1;

endpackage

// File: rtl/shr_seq.sv
// Multi-cycle right shifter (logical or arithmetic), one bit per clock under a
// start/busy/done handshake. Shift amounts at or above DATAWIDTH saturate.
module shr_seq
    import shr_seq_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int SHAMTWIDTH = 4,
    parameter int SIGNED     = SHIFT_LOGICAL
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [DATAWIDTH-1:0]  a,
    input  logic [SHAMTWIDTH-1:0] sh_amt,
    output logic                  busy,
    output logic                  done,
    output logic [DATAWIDTH-1:0]  d
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam int AW = (SHAMTWIDTH > CW) ? SHAMTWIDTH : CW;

    function automatic logic [DATAWIDTH-1:0] shr1(input logic [DATAWIDTH-1:0] v);
        logic fill;
        fill = (SIGNED == SHIFT_ARITH) ? v[DATAWIDTH-1] : 1'b0;
        return {fill, v[DATAWIDTH-1:1]};
    endfunction

    state_t                 state, state_nx;
    logic [DATAWIDTH-1:0]   sreg, sreg_nx, sreg_sh;
    logic [CW-1:0]          cnt, cnt_nx, n_eff;
    logic [DATAWIDTH-1:0]   d_nx;
    logic                   done_nx;
    logic [AW-1:0]          amt_w;

    // Saturate the requested amount so latency never exceeds DATAWIDTH shifts.
    always_comb begin
        amt_w = AW'(sh_amt);
        n_eff = (amt_w >= AW'(DATAWIDTH)) ? CW'(DATAWIDTH) : CW'(amt_w);
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        d_nx     = d;
        done_nx  = 1'b0;
        sreg_sh  = shr1(sreg);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_eff == '0) begin
                        d_nx    = a;
                        done_nx = 1'b1;
                    end else begin
                        sreg_nx  = a;
                        cnt_nx   = n_eff;
                        state_nx = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                sreg_nx = sreg_sh;
                cnt_nx  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    d_nx     = sreg_sh;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            d     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            d     <= d_nx;
            done  <= done_nx;
        end
    end

    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_shr_seq.sv
// Bench for shr_seq: a logical and an arithmetic instance share stimulus;
// expected results and completion cycles are queued and matched on done.
module tb_shr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [3:0] sh_amt;
    logic       busy_l, done_l, busy_a, done_a;
    logic [7:0] d_l, d_a;

    always #5 clk = ~clk;

    shr_seq #(.DATAWIDTH(8), .SHAMTWIDTH(4), .SIGNED(0)) u_log (
        .Clk(clk), .Rst(rst), .start(start), .a(a), .sh_amt(sh_amt),
        .busy(busy_l), .done(done_l), .d(d_l)
    );

    shr_seq #(.DATAWIDTH(8), .SHAMTWIDTH(4), .SIGNED(1)) u_ari (
        .Clk(clk), .Rst(rst), .start(start), .a(a), .sh_amt(sh_amt),
        .busy(busy_a), .done(done_a), .d(d_a)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q_l[$];
    exp_t q_a[$];
    exp_t e_l, e_a;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_n(input logic [3:0] s);
        return (s > 4'd8) ? 8 : int'(s);
    endfunction

    function automatic logic [7:0] model(input logic [7:0] v, input logic [3:0] s, input bit ari);
        int n;
        n = eff_n(s);
        if (ari) return 8'($signed(v) >>> n);
        return v >> n;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_l) begin
            if (q_l.size() == 0) check("log_spurious_done", {31'b0, done_l}, 32'h0);
            else begin
                e_l = q_l.pop_front();
                check("log_d", {24'b0, d_l}, {24'b0, e_l.data});
                check("log_latency", cyc, e_l.cyc);
            end
        end
        if (done_a) begin
            if (q_a.size() == 0) check("ari_spurious_done", {31'b0, done_a}, 32'h0);
            else begin
                e_a = q_a.pop_front();
                check("ari_d", {24'b0, d_a}, {24'b0, e_a.data});
                check("ari_latency", cyc, e_a.cyc);
            end
        end
    end

    // Called at a falling edge; the following rising edge accepts the request.
    task automatic drive(input logic [7:0] av, input logic [3:0] s);
        exp_t el, ea;
        start     = 1'b1;
        a         = av;
        sh_amt    = s;
        el.data   = model(av, s, 1'b0);
        el.cyc    = cyc + 1 + eff_n(s);
        ea.data   = model(av, s, 1'b1);
        ea.cyc    = el.cyc;
        q_l.push_back(el);
        q_a.push_back(ea);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy_l && !busy_a) return;
            @(negedge clk);
        end
        check("idle_timeout", {31'b0, busy_l}, 32'h0);
    endtask

    task automatic op(input logic [7:0] av, input logic [3:0] s);
        drive(av, s);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'b0, busy_l}, {31'b0, (eff_n(s) != 0)});
        wait_idle();
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        sh_amt = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, busy_l | busy_a}, 32'h0);
        check("rst_done", {31'b0, done_l | done_a}, 32'h0);
        check("rst_d_log", {24'b0, d_l}, 32'h0);
        check("rst_d_ari", {24'b0, d_a}, 32'h0);

        op(8'hB4, 4'd3);
        op(8'h74, 4'd3);
        op(8'h5A, 4'd0);
        op(8'h81, 4'd12);
        op(8'h81, 4'd8);
        op(8'hC5, 4'd1);

        // Start while busy is ignored; operand changes mid-shift have no effect.
        drive(8'hF0, 4'd4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        a      = 8'h0F;
        sh_amt = 4'd1;
        @(negedge clk);
        start  = 1'b0;
        a      = 8'hAA;
        sh_amt = 4'd2;
        for (int i = 0; i < 20 && !done_l; i++) @(negedge clk);
        check("done_seen", {31'b0, done_l}, 32'h1);
        drive(8'h3C, 4'd2);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);

        // Reset in the middle of a 5-bit shift aborts it silently.
        drive(8'hC3, 4'd5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_l.delete();
        q_a.delete();
        check("abort_busy", {31'b0, busy_l | busy_a}, 32'h0);
        check("abort_done", {31'b0, done_l | done_a}, 32'h0);
        check("abort_d_log", {24'b0, d_l}, 32'h0);
        check("abort_d_ari", {24'b0, d_a}, 32'h0);
        repeat (8) @(negedge clk);
        op(8'hC3, 4'd5);

        for (int k = 0; k < 6; k++) op(8'($urandom_range(255)), 4'($urandom_range(15)));

        repeat (12) @(negedge clk);
        check("log_queue_drained", q_l.size(), 32'h0);
        check("ari_queue_drained", q_a.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
